// File: rtl/axis_video_if.sv
// AXI4-Stream video bus: one RGB pixel per beat, tlast marks end of line, tuser marks start of frame.
interface axis_video_if #(
   parameter int AXI_WIDTH = 24
) ();
   logic [AXI_WIDTH-1:0] tdata;
   logic                 tvalid;
   logic                 tready;
   logic                 tlast;
   logic                 tuser;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tuser,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tuser,
      output tready
   );
endinterface

// File: rtl/axis_video_tx.sv
// AXI4-Stream video master: frames an upstream pixel stream into IMG_LENGTH lines of IMG_WIDTH
// pixels through a single output register, with optional blanking cycles after each line.
module axis_video_tx #(
   parameter int IMG_WIDTH  = 416,
   parameter int IMG_LENGTH = 150,
   parameter int AXI_WIDTH  = 24,
   parameter int LINE_GAP   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         continuous,
   input  logic [AXI_WIDTH-1:0]         in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   axis_video_if.master                 m_axi_video,
   output logic                         busy,
   output logic                         frame_done,
   output logic [$clog2(IMG_LENGTH):0]  cur_row
);

   localparam int ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RowW = $clog2(IMG_LENGTH) + 1;
   localparam int GapW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

   localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_LENGTH - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(LINE_GAP - 1);

   typedef enum logic [1:0] {StIdle, StActive, StGap, StDrain} state_e;

   state_e               state_q, state_d;
   logic [ColW-1:0]      col_q, col_d;
   logic [RowW-1:0]      row_q, row_d;
   logic [GapW-1:0]      gap_q, gap_d;
   logic [AXI_WIDTH-1:0] tdata_q;
   logic                 tvalid_q, tlast_q, tuser_q;
   logic                 load, beat_done;

   // The output slot may be refilled in the same cycle it drains, giving one pixel per cycle.
   assign in_ready   = (state_q == StActive) && (!tvalid_q || m_axi_video.tready);
   assign load       = in_ready && in_valid;
   assign beat_done  = tvalid_q && m_axi_video.tready;
   assign busy       = (state_q != StIdle);
   assign frame_done = (state_q == StDrain) && beat_done;
   assign cur_row    = row_q;

   assign m_axi_video.tdata  = tdata_q;
   assign m_axi_video.tvalid = tvalid_q;
   assign m_axi_video.tlast  = tlast_q;
   assign m_axi_video.tuser  = tuser_q;

   // Next-state and pixel position counters.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      gap_d   = gap_q;
      unique case (state_q)
         StIdle: begin
            col_d = '0;
            row_d = '0;
            if (start || continuous) state_d = StActive;
         end
         StActive: begin
            if (load) begin
               if (col_q == ColLast) begin
                  col_d = '0;
                  row_d = row_q + RowW'(1);
                  if (row_q == RowLast) begin
                     state_d = StDrain;
                  end else if (LINE_GAP > 0) begin
                     state_d = StGap;
                     gap_d   = '0;
                  end
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end
         StGap: begin
            if (gap_q == GapLast) state_d = StActive;
            else                  gap_d   = gap_q + GapW'(1);
         end
         StDrain: begin
            // Last pixel is already loaded; wait for it to leave before closing the frame.
            if (beat_done) begin
               col_d   = '0;
               row_d   = '0;
               state_d = continuous ? StActive : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         gap_q   <= gap_d;
      end
   end

   // Single-stage output register; holds its beat until the downstream accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end else if (load) begin
         tdata_q  <= in_data;
         tvalid_q <= 1'b1;
         tlast_q  <= (col_q == ColLast);
         tuser_q  <= (col_q == '0) && (row_q == '0);
      end else if (beat_done) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_video_tx.sv
// Bench for axis_video_tx: two instances (no line gap, two-cycle line gap) share clock, reset,
// start and downstream ready; beats are collected at the falling edge and compared to a model.
module tb_axis_video_tx;

   localparam int W  = 4;
   localparam int L  = 3;
   localparam int FP = W * L;

   logic        clk = 1'b0;
   logic        rst, start, tready, src_en, sb_clr;
   logic        cont_a, cont_b;
   logic [23:0] pix_a, pix_b;
   logic        rdy_a, rdy_b, busy_a, busy_b, fdp_a, fdp_b;
   logic [2:0]  row_a, row_b;

   int tests_run = 0;
   int tests_failed = 0;

   axis_video_if #(.AXI_WIDTH(24)) ifa ();
   axis_video_if #(.AXI_WIDTH(24)) ifb ();
   assign ifa.tready = tready;
   assign ifb.tready = tready;

   axis_video_tx #(.IMG_WIDTH(W), .IMG_LENGTH(L), .AXI_WIDTH(24), .LINE_GAP(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .continuous(cont_a),
      .in_data(pix_a), .in_valid(src_en), .in_ready(rdy_a),
      .m_axi_video(ifa), .busy(busy_a), .frame_done(fdp_a), .cur_row(row_a)
   );

   axis_video_tx #(.IMG_WIDTH(W), .IMG_LENGTH(L), .AXI_WIDTH(24), .LINE_GAP(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .continuous(cont_b),
      .in_data(pix_b), .in_valid(src_en), .in_ready(rdy_b),
      .m_axi_video(ifb), .busy(busy_b), .frame_done(fdp_b), .cur_row(row_b)
   );

   always #5 clk = ~clk;

   // Pixel sources: value = 1 + number of pixels accepted since the last clear.
   always @(posedge clk) begin
      if (sb_clr) begin
         pix_a <= 24'd1;
         pix_b <= 24'd1;
      end else begin
         if (src_en && rdy_a) pix_a <= pix_a + 24'd1;
         if (src_en && rdy_b) pix_b <= pix_b + 24'd1;
      end
   end

   // Monitors: beats as {tuser, tlast, tdata}, frame_done positions, post-frame status, stalls.
   int          ncyc = 0;
   logic [25:0] beats_a[$], beats_b[$];
   int          cyc_a[$], cyc_b[$], fdpos_a[$], fdpos_b[$];
   logic [3:0]  after_a[$], after_b[$];
   bit          rdy_tr_b[$];
   int          ld_tr_b[$];
   int          fd_a = 0, fd_b = 0, viol_a = 0, viol_b = 0;
   logic        stall_a = 0, stall_b = 0, chk_a = 0, chk_b = 0;
   logic [25:0] held_a, held_b;

   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (sb_clr) begin
         beats_a.delete(); cyc_a.delete(); fdpos_a.delete(); after_a.delete();
         fd_a <= 0; viol_a <= 0; stall_a <= 0; chk_a <= 0;
      end else if (rst) begin
         stall_a <= 0; chk_a <= 0;
      end else begin
         if (stall_a && (!ifa.tvalid || {ifa.tuser, ifa.tlast, ifa.tdata} !== held_a))
            viol_a <= viol_a + 1;
         stall_a <= ifa.tvalid && !ifa.tready;
         held_a  <= {ifa.tuser, ifa.tlast, ifa.tdata};
         if (ifa.tvalid && ifa.tready) begin
            beats_a.push_back({ifa.tuser, ifa.tlast, ifa.tdata});
            cyc_a.push_back(ncyc);
         end
         if (chk_a) after_a.push_back({busy_a, row_a});
         chk_a <= fdp_a;
         if (fdp_a) begin
            fdpos_a.push_back(beats_a.size());
            fd_a <= fd_a + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (sb_clr) begin
         beats_b.delete(); cyc_b.delete(); fdpos_b.delete(); after_b.delete();
         rdy_tr_b.delete(); ld_tr_b.delete();
         fd_b <= 0; viol_b <= 0; stall_b <= 0; chk_b <= 0;
      end else if (rst) begin
         stall_b <= 0; chk_b <= 0;
      end else begin
         if (stall_b && (!ifb.tvalid || {ifb.tuser, ifb.tlast, ifb.tdata} !== held_b))
            viol_b <= viol_b + 1;
         stall_b <= ifb.tvalid && !ifb.tready;
         held_b  <= {ifb.tuser, ifb.tlast, ifb.tdata};
         if (ifb.tvalid && ifb.tready) begin
            beats_b.push_back({ifb.tuser, ifb.tlast, ifb.tdata});
            cyc_b.push_back(ncyc);
         end
         rdy_tr_b.push_back(rdy_b);
         ld_tr_b.push_back((src_en && rdy_b) ? int'(pix_b) : 0);
         if (chk_b) after_b.push_back({busy_b, row_b});
         chk_b <= fdp_b;
         if (fdp_b) begin
            fdpos_b.push_back(beats_b.size());
            fd_b <= fd_b + 1;
         end
      end
   end

   // Reference: beat k of a run carries pixel k+1, tlast every W-th beat, tuser every frame start.
   function automatic logic [25:0] exp_beat(input int k);
      logic u, t;
      u = ((k % FP) == 0);
      t = ((k % W) == W - 1);
      return {u, t, 24'(k + 1)};
   endfunction

   task automatic clear_sb();
      sb_clr = 1'b1;
      @(posedge clk); #1;
      sb_clr = 1'b0;
   endtask

   // tr_mode: 0 always ready, 1 toggle 1,0,1,0, 2 random. src_mode: 0 always valid, 2 random.
   task automatic drive(input int frames, input bit want_cont, input int tr_mode,
                        input int src_mode, input bit mid_start, output bit timed_out);
      int cyc = 0;
      bit pulsed = 0;
      cont_a = want_cont && (frames > 1);
      cont_b = cont_a;
      tready = 1'b1;
      src_en = 1'b1;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      while ((fd_a < frames || fd_b < frames) && cyc < 800) begin
         case (tr_mode)
            0: tready = 1'b1;
            1: tready = (cyc % 2 == 0);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         src_en = (src_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         start  = 1'b0;
         if (mid_start && !pulsed && beats_a.size() >= 5) begin
            start  = 1'b1;
            pulsed = 1;
         end
         cont_a = want_cont && (fd_a < frames - 1);
         cont_b = want_cont && (fd_b < frames - 1);
         @(posedge clk); #1;
         cyc++;
      end
      timed_out = (cyc >= 800);
      start  = 1'b0;
      cont_a = 1'b0;
      cont_b = 1'b0;
      tready = 1'b1;
      src_en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      src_en = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({ifa.tvalid, ifa.tlast, ifa.tuser, ifa.tdata, rdy_a, busy_a, fdp_a, row_a} !== '0) begin
         tests_failed++;
         $display("FAIL reset_a got tvalid=%b busy=%b tdata=%h row=%0d want all 0",
                  ifa.tvalid, busy_a, ifa.tdata, row_a);
      end
      tests_run++;
      if ({ifb.tvalid, ifb.tlast, ifb.tuser, ifb.tdata, rdy_b, busy_b, fdp_b, row_b} !== '0) begin
         tests_failed++;
         $display("FAIL reset_b got tvalid=%b busy=%b tdata=%h row=%0d want all 0",
                  ifb.tvalid, busy_b, ifb.tdata, row_b);
      end
   endtask

   task automatic test_basic();
      bit to;
      clear_sb();
      drive(1, 0, 0, 0, 0, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL basic_timeout got timeout want done"); end
      tests_run++;
      if (beats_a.size() !== FP || beats_b.size() !== FP) begin
         tests_failed++;
         $display("FAIL basic_count got a=%0d b=%0d want %0d", beats_a.size(), beats_b.size(), FP);
      end
      for (int k = 0; k < beats_a.size(); k++) begin
         tests_run++;
         if (beats_a[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL basic_a_beat%0d got %h want %h", k, beats_a[k], exp_beat(k));
         end
      end
      for (int k = 0; k < beats_b.size(); k++) begin
         tests_run++;
         if (beats_b[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL basic_b_beat%0d got %h want %h", k, beats_b[k], exp_beat(k));
         end
      end
      if (cyc_a.size() == FP && cyc_b.size() == FP) begin
         tests_run++;
         if (cyc_a[FP-1] - cyc_a[0] !== FP - 1) begin
            tests_failed++;
            $display("FAIL basic_a_span got %0d want %0d", cyc_a[FP-1] - cyc_a[0], FP - 1);
         end
         tests_run++;
         if (cyc_b[FP-1] - cyc_b[0] !== FP - 1 + 2 * (L - 1)) begin
            tests_failed++;
            $display("FAIL basic_b_span got %0d want %0d", cyc_b[FP-1] - cyc_b[0],
                     FP - 1 + 2 * (L - 1));
         end
      end
      tests_run++;
      if (fdpos_a.size() !== 1 || fdpos_a[0] !== FP || fdpos_b.size() !== 1 || fdpos_b[0] !== FP) begin
         tests_failed++;
         $display("FAIL basic_frame_done got a=%0d pulses b=%0d pulses want 1 each at beat %0d",
                  fdpos_a.size(), fdpos_b.size(), FP);
      end
      tests_run++;
      if (after_a.size() !== 1 || after_a[0] !== 4'b0000 || after_b.size() !== 1 ||
          after_b[0] !== 4'b0000) begin
         tests_failed++;
         $display("FAIL basic_busy_after got a=%0d entries b=%0d entries want busy=0 row=0",
                  after_a.size(), after_b.size());
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_sb();
      drive(1, 0, 1, 0, 0, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL bp_timeout got timeout want done"); end
      tests_run++;
      if (beats_a.size() !== FP || beats_b.size() !== FP) begin
         tests_failed++;
         $display("FAIL bp_count got a=%0d b=%0d want %0d", beats_a.size(), beats_b.size(), FP);
      end
      for (int k = 0; k < beats_a.size(); k++) begin
         tests_run++;
         if (beats_a[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL bp_a_beat%0d got %h want %h", k, beats_a[k], exp_beat(k));
         end
      end
      for (int k = 0; k < beats_b.size(); k++) begin
         tests_run++;
         if (beats_b[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL bp_b_beat%0d got %h want %h", k, beats_b[k], exp_beat(k));
         end
      end
      tests_run++;
      if (viol_a !== 0 || viol_b !== 0) begin
         tests_failed++;
         $display("FAIL bp_stability got a=%0d b=%0d changes while stalled want 0", viol_a, viol_b);
      end
   endtask

   task automatic test_line_gap();
      bit to;
      int found = 0;
      clear_sb();
      drive(1, 0, 0, 0, 0, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL gap_timeout got timeout want done"); end
      for (int i = 0; i + 3 < ld_tr_b.size(); i++) begin
         if (ld_tr_b[i] == W || ld_tr_b[i] == 2 * W) begin
            found++;
            tests_run++;
            if ({rdy_tr_b[i+1], rdy_tr_b[i+2], rdy_tr_b[i+3]} !== 3'b001) begin
               tests_failed++;
               $display("FAIL gap_after_px%0d got in_ready %b%b%b want 001", ld_tr_b[i],
                        rdy_tr_b[i+1], rdy_tr_b[i+2], rdy_tr_b[i+3]);
            end
         end
      end
      tests_run++;
      if (found !== L - 1) begin
         tests_failed++;
         $display("FAIL gap_line_ends got %0d want %0d", found, L - 1);
      end
   endtask

   task automatic test_continuous();
      bit to;
      clear_sb();
      drive(2, 1, 0, 0, 0, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL cont_timeout got timeout want done"); end
      tests_run++;
      if (beats_a.size() !== 2 * FP || beats_b.size() !== 2 * FP) begin
         tests_failed++;
         $display("FAIL cont_count got a=%0d b=%0d want %0d", beats_a.size(), beats_b.size(),
                  2 * FP);
      end
      for (int k = 0; k < beats_a.size(); k++) begin
         tests_run++;
         if (beats_a[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL cont_a_beat%0d got %h want %h", k, beats_a[k], exp_beat(k));
         end
      end
      for (int k = 0; k < beats_b.size(); k++) begin
         tests_run++;
         if (beats_b[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL cont_b_beat%0d got %h want %h", k, beats_b[k], exp_beat(k));
         end
      end
      tests_run++;
      if (fdpos_a.size() !== 2 || fdpos_a[0] !== FP || fdpos_a[1] !== 2 * FP) begin
         tests_failed++;
         $display("FAIL cont_frame_done got %0d pulses want 2 at beats %0d,%0d",
                  fdpos_a.size(), FP, 2 * FP);
      end
      tests_run++;
      if (after_a.size() !== 2 || after_a[0] !== 4'b1000 || after_a[1] !== 4'b0000) begin
         tests_failed++;
         $display("FAIL cont_row_between got %0d entries first=%b want busy=1 row=0 then idle",
                  after_a.size(), (after_a.size() > 0) ? after_a[0] : 4'hx);
      end
   endtask

   task automatic test_mid_start();
      bit to;
      clear_sb();
      drive(1, 0, 0, 0, 1, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL midstart_timeout got timeout want done"); end
      tests_run++;
      if (beats_a.size() !== FP || beats_b.size() !== FP || fd_a !== 1 || fd_b !== 1) begin
         tests_failed++;
         $display("FAIL midstart_count got a=%0d b=%0d frames=%0d/%0d want %0d beats 1 frame",
                  beats_a.size(), beats_b.size(), fd_a, fd_b, FP);
      end
   endtask

   task automatic test_random();
      bit to;
      for (int r = 0; r < 3; r++) begin
         clear_sb();
         drive(1, 0, 2, 2, 0, to);
         tests_run++;
         if (to) begin tests_failed++; $display("FAIL rand%0d_timeout got timeout want done", r); end
         tests_run++;
         if (beats_a.size() !== FP || beats_b.size() !== FP) begin
            tests_failed++;
            $display("FAIL rand%0d_count got a=%0d b=%0d want %0d", r, beats_a.size(),
                     beats_b.size(), FP);
         end
         for (int k = 0; k < beats_a.size(); k++) begin
            tests_run++;
            if (beats_a[k] !== exp_beat(k) || (k < beats_b.size() && beats_b[k] !== exp_beat(k))) begin
               tests_failed++;
               $display("FAIL rand%0d_beat%0d got a=%h want %h", r, k, beats_a[k], exp_beat(k));
            end
         end
         tests_run++;
         if (viol_a !== 0 || viol_b !== 0 || fdpos_a.size() !== 1 || fdpos_a[0] !== FP) begin
            tests_failed++;
            $display("FAIL rand%0d_stall_fd got viol=%0d/%0d fd=%0d want 0/0 1", r, viol_a,
                     viol_b, fdpos_a.size());
         end
      end
   endtask

   task automatic test_async_reset();
      bit to;
      int n = 0;
      clear_sb();
      tready = 1'b1;
      src_en = 1'b1;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      while (beats_a.size() < 6 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      tests_run++;
      if (ifa.tvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL arst_pre got tvalid=%b want 1", ifa.tvalid);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({ifa.tvalid, ifa.tlast, ifa.tuser, ifa.tdata, rdy_a, busy_a, fdp_a, row_a} !== '0) begin
         tests_failed++;
         $display("FAIL arst_a got tvalid=%b busy=%b tdata=%h want all 0", ifa.tvalid, busy_a,
                  ifa.tdata);
      end
      tests_run++;
      if ({ifb.tvalid, ifb.tlast, ifb.tuser, ifb.tdata, rdy_b, busy_b, fdp_b, row_b} !== '0) begin
         tests_failed++;
         $display("FAIL arst_b got tvalid=%b busy=%b tdata=%h want all 0", ifb.tvalid, busy_b,
                  ifb.tdata);
      end
      src_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_sb();
      drive(1, 0, 0, 0, 0, to);
      tests_run++;
      if (to || beats_a.size() !== FP || beats_b.size() !== FP) begin
         tests_failed++;
         $display("FAIL arst_refresh got a=%0d b=%0d beats timeout=%b want %0d", beats_a.size(),
                  beats_b.size(), to, FP);
      end
      for (int k = 0; k < beats_a.size(); k++) begin
         tests_run++;
         if (beats_a[k] !== exp_beat(k)) begin
            tests_failed++;
            $display("FAIL arst_a_beat%0d got %h want %h", k, beats_a[k], exp_beat(k));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tready = 1'b0; src_en = 1'b0; sb_clr = 1'b0;
      cont_a = 1'b0; cont_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      clear_sb();
      test_basic();
      test_backpressure();
      test_line_gap();
      test_continuous();
      test_mid_start();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axis_video_tx.md
Name: axis_video_tx

Overview:
- AXI4-Stream video master: the transmitting end of the video stream interface that the lane-detection input consumes.
- Takes RGB pixels from an upstream pixel source (frame-buffer reader or test pattern FIFO) over a valid/ready handshake.
- Frames them into IMG_LENGTH lines of IMG_WIDTH pixels, driving tdata/tvalid/tlast/tuser.
- Inserts optional inter-line blanking, reports frame completion, and feeds simulation benches and loopback builds.

Parameters:
- IMG_WIDTH, 416, pixels per line
- IMG_LENGTH, 150, lines per frame
- AXI_WIDTH, 24, tdata width (one RGB pixel per beat)
- LINE_GAP, 0, idle cycles inserted after each line's last pixel is loaded (0 = none)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
- continuous  in  1  when 1, a new frame begins automatically after each frame_done
- in_data  in  AXI_WIDTH  pixel from source
- in_valid  in  1  in_data valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- m_axi_video_tdata  out  AXI_WIDTH  output pixel
- m_axi_video_tvalid  out  1  output beat valid
- m_axi_video_tready  in  1  downstream ready
- m_axi_video_tlast  out  1  last pixel of line
- m_axi_video_tuser  out  1  first pixel of frame (SOF)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when the last beat of a frame is handshaken
- cur_row  out  $clog2(IMG_LENGTH)+1  line index of next pixel to load

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: immediate on rst. All outputs 0, state IDLE, counters 0. tvalid drops even mid-beat; this is accepted.
- States:
  - IDLE: start or continuous -> ACTIVE; col=row=0.
  - ACTIVE: loads pixels. On load of col==IMG_WIDTH-1:
    - if row==IMG_LENGTH-1 -> DRAIN
    - else if LINE_GAP>0 -> GAP
    - else stay ACTIVE
  - GAP: counts LINE_GAP cycles with in_ready=0, then -> ACTIVE.
  - DRAIN: waits for the final beat handshake, pulses frame_done, then -> ACTIVE (continuous=1, counters cleared) or IDLE.
- Output register: single stage.
  - in_ready = (state==ACTIVE) && (!tvalid || tready).
  - On load: tdata<=in_data, tvalid<=1, tlast<=(col==IMG_WIDTH-1), tuser<=(col==0 && row==0).
  - On tready && tvalid with no load: tvalid<=0.
  - Simultaneous handshake and load is full throughput: 1 pixel/cycle with no gaps when LINE_GAP=0.
- AXI stability: while tvalid && !tready, tdata/tlast/tuser hold constant.
- Latency: 1 cycle from input acceptance to tvalid.
- Counters:
  - col increments on load and wraps to 0 after IMG_WIDTH-1, at which point row increments.
  - row clears on entry to a new frame.
  - cur_row = row.
- start while busy: ignored, no queuing. start and continuous together in IDLE: a single frame begins.
- Upstream stall (in_valid=0): no beat inserted and counters hold. tvalid falls after any pending beat drains.
- Downstream stall with tvalid=1: in_ready=0, so no input is lost.
- frame_done is asserted only in DRAIN, in the cycle of the final handshake. tlast and tuser are never asserted outside the positions defined above.

Test Plan (IMG_WIDTH=4, IMG_LENGTH=3):
- LINE_GAP=0, start pulse, in_valid and tready held high, in_data=0x000001..0x00000C -> 12 consecutive beats; tuser only on 0x000001; tlast on 0x000004/0x000008/0x00000C; frame_done on the cycle of beat 12; busy low the next cycle.
- Same stimulus with tready toggling 1,0,1,0 -> tdata/tlast/tuser constant during every tready=0 cycle; exactly 12 beats; no duplicates or drops.
- LINE_GAP=2 -> in_ready low for exactly 2 cycles after pixels 4 and 8 are loaded; beat order unchanged.
- continuous=1 for 2 frames -> 24 beats; tuser on beats 1 and 13; two frame_done pulses; row returns to 0 between frames.
- start pulsed again mid-frame (after beat 5) -> ignored; the frame still completes in exactly 12 beats.
- rst asserted after beat 6 while tvalid=1 -> all outputs 0 the same cycle; the next start yields a fresh frame with tuser on its first beat.
